// File: rtl/d_latch_bist.sv
// Built-in self test for a D latch: sweeps the four {en,d} vectors, settles,
// and checks the latch outputs against a simple hold/transparent model.
module d_latch_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       en_o,
  output logic       d_o,
  input  logic       q_i,
  input  logic       qb_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] err_cnt_o,
  output logic [1:0] fail_vec_o
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned PASS_W  = 8;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned ERR_MAX = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic               known_q, known_d;
  logic               model_q, model_d;
  logic               first_q, first_d;
  logic               en_q, en_d;
  logic               d_q, d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [1:0]         fv_q, fv_d;

  logic               exp_q_c;
  logic               known_c;
  logic               mismatch_c;

  // Reference model: transparent when enabled, otherwise the last captured value.
  always_comb begin
    exp_q_c    = en_q ? d_q : model_q;
    known_c    = en_q | known_q;
    mismatch_c = (known_c && (q_i != exp_q_c)) || (qb_i == q_i);
  end

  // Next-state and datapath updates; abort overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    known_d    = known_q;
    model_d    = model_q;
    first_d    = first_q;
    en_d       = en_q;
    d_d        = d_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fv_d       = fv_q;

    if ((state_q != ST_IDLE) && abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d    = ST_DRIVE;
            err_d      = '0;
            first_d    = 1'b0;
            idx_d      = IDX_W'(3);
            pass_cnt_d = '0;
            known_d    = 1'b0;
          end
        end
        ST_DRIVE: begin
          en_d     = idx_q[1];
          d_d      = idx_q[0];
          settle_d = CNT_W'(SETTLE_CYCLES - 1);
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            settle_d = settle_q - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (en_q) begin
            known_d = 1'b1;
            model_d = d_q;
          end
          if (mismatch_c) begin
            if (err_q != ERR_W'(ERR_MAX)) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!first_q) begin
              fv_d    = {en_q, d_q};
              first_d = 1'b1;
            end
          end
          if (idx_q != '0) begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_DRIVE;
          end else begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
            if (pass_cnt_d == PASS_W'(NUM_PASSES)) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = IDX_W'(3);
              state_d = ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          pass_d  = (err_q == '0);
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      known_q    <= 1'b0;
      model_q    <= 1'b0;
      first_q    <= 1'b0;
      en_q       <= 1'b0;
      d_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fv_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      known_q    <= known_d;
      model_q    <= model_d;
      first_q    <= first_d;
      en_q       <= en_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
    end
  end

  assign en_o       = en_q;
  assign d_o        = d_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign fail_vec_o = fv_q;

endmodule

// File: tb/tb_d_latch_bist.sv
// Self-checking bench: three BIST instances with different settle/pass
// settings, each driving a behavioural latch with a selectable fault.
module tb_d_latch_bist;

  localparam int NDUT    = 3;
  localparam int TIMEOUT = 1200;
  localparam int S_TAB [NDUT] = '{2, 3, 1};
  localparam int N_TAB [NDUT] = '{1, 2, 70};

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  int   mode;

  logic       en   [NDUT];
  logic       d    [NDUT];
  logic       q    [NDUT];
  logic       qb   [NDUT];
  logic       lq   [NDUT];
  logic       busy [NDUT];
  logic       done [NDUT];
  logic       pass [NDUT];
  logic [7:0] ec   [NDUT];
  logic [1:0] fv   [NDUT];

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_fv   [NDUT];
  logic       exp_pass [NDUT];

  always #5 clk = ~clk;

  d_latch_bist #(.SETTLE_CYCLES(2), .NUM_PASSES(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .en_o(en[0]), .d_o(d[0]), .q_i(q[0]), .qb_i(qb[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
    .err_cnt_o(ec[0]), .fail_vec_o(fv[0]));

  d_latch_bist #(.SETTLE_CYCLES(3), .NUM_PASSES(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .en_o(en[1]), .d_o(d[1]), .q_i(q[1]), .qb_i(qb[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
    .err_cnt_o(ec[1]), .fail_vec_o(fv[1]));

  d_latch_bist #(.SETTLE_CYCLES(1), .NUM_PASSES(70)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .en_o(en[2]), .d_o(d[2]), .q_i(q[2]), .qb_i(qb[2]),
    .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]),
    .err_cnt_o(ec[2]), .fail_vec_o(fv[2]));

  // Latch under test: 0 ideal, 1 q stuck 0, 2 ignores en, 3 qb equals q, 4 inverted
  function automatic logic lat_q(input logic e, input logic dd, input logic h, input int m);
    logic ideal;
    ideal = e ? dd : h;
    case (m)
      1:       return 1'b0;
      2:       return dd;
      4:       return ~ideal;
      default: return ideal;
    endcase
  endfunction

  function automatic logic lat_qb(input logic e, input logic dd, input logic h, input int m);
    logic qq;
    qq = lat_q(e, dd, h, m);
    return (m == 3) ? qq : ~qq;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (en[i]) lq[i] <= d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      q[i]  = lat_q(en[i], d[i], lq[i], mode);
      qb[i] = lat_qb(en[i], d[i], lq[i], mode);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Whole-run outcome from the rules: sweep vectors 3..0, apply the hold model.
  task automatic ref_run(input int m, input int np, output int errs, output logic [1:0] fvx);
    logic known, mv, held, e, dd, qo, qbo, expq;
    bit   first;
    errs  = 0;
    fvx   = 2'b00;
    first = 1'b1;
    known = 1'b0;
    mv    = 1'b0;
    held  = 1'b0;
    for (int p = 0; p < np; p++) begin
      for (int v = 3; v >= 0; v--) begin
        e  = 1'((v >> 1) & 1);
        dd = 1'(v & 1);
        if (e) held = dd;
        qo   = lat_q(e, dd, held, m);
        qbo  = lat_qb(e, dd, held, m);
        expq = e ? dd : mv;
        if (e) begin
          known = 1'b1;
          mv    = dd;
        end
        if ((known && (qo != expq)) || (qbo == qo)) begin
          if (errs < 255) errs++;
          if (first) begin
            fvx   = 2'(v);
            first = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic do_run(input int m);
    int         er [NDUT];
    logic [1:0] fvx;
    int         seen [NDUT];
    int         k;
    int         maxk;
    bit         all_seen;
    mode = m;
    for (int i = 0; i < NDUT; i++) begin
      ref_run(m, N_TAB[i], er[i], fvx);
      if (er[i] > 0) exp_fv[i] = fvx;
      exp_pass[i] = (er[i] == 0);
      seen[i] = -1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int i = 0; i < NDUT; i++) check($sformatf("busy_run%0d", i), 32'(busy[i]), 1);
    while (k < TIMEOUT) begin
      all_seen = 1'b1;
      maxk = 0;
      for (int i = 0; i < NDUT; i++) begin
        if (seen[i] < 0 && done[i]) seen[i] = k;
        if (seen[i] >= 0 && k == seen[i] + 1) check($sformatf("done_width%0d", i), 32'(done[i]), 0);
        if (seen[i] < 0) all_seen = 1'b0;
        if (seen[i] > maxk) maxk = seen[i];
      end
      if (k >= 1 && k <= 13 && (k % 4) == 1) check("stim_seq", 32'({en[0], d[0]}), 32'(3 - k / 4));
      if (all_seen && k > maxk + 2) break;
      @(posedge clk); #1;
      k++;
    end
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("done_lat%0d", i), 32'(seen[i]), 32'(4 * N_TAB[i] * (S_TAB[i] + 2)));
      check($sformatf("err_cnt%0d", i), 32'(ec[i]), 32'(er[i]));
      check($sformatf("fail_vec%0d", i), 32'(fv[i]), 32'(exp_fv[i]));
      check($sformatf("pass%0d", i), 32'(pass[i]), 32'(exp_pass[i]));
      check($sformatf("busy_end%0d", i), 32'(busy[i]), 0);
    end
  endtask

  // Abort raised after edge k_ab of a run; only modes 0 and 3 have a simple partial count.
  task automatic abort_at(input int m, input int k_ab);
    int  part;
    bit  saw_done;
    mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < k_ab; k++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_stim", 32'({en[0], d[0]}), 32'(3 - (k_ab - 1) / 4));
    for (int i = 0; i < NDUT; i++) begin
      part = (m == 3) ? k_ab / (S_TAB[i] + 2) : 0;
      if (part > 0) exp_fv[i] = 2'b11;
      check($sformatf("abort_busy%0d", i), 32'(busy[i]), 0);
      check($sformatf("abort_err%0d", i), 32'(ec[i]), 32'(part));
      check($sformatf("abort_fv%0d", i), 32'(fv[i]), 32'(exp_fv[i]));
      check($sformatf("abort_pass%0d", i), 32'(pass[i]), 32'(exp_pass[i]));
    end
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NDUT; i++) if (done[i]) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(saw_done), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_outs%0d", tag, i),
            32'({en[i], d[i], busy[i], done[i], pass[i], ec[i], fv[i]}), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    for (int i = 0; i < NDUT; i++) begin
      exp_fv[i]   = 2'b00;
      exp_pass[i] = 1'b0;
    end
    #1;
    check_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_idle");

    for (int m = 0; m < 5; m++) do_run(m);

    abort_at(0, 6);
    do_run(0);
    for (int r = 0; r < 3; r++) abort_at(3, int'($urandom_range(1, 14)));

    mode  = 0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < NDUT; i++) check($sformatf("start_wins%0d", i), 32'(busy[i]), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("abort2_busy%0d", i), 32'(busy[i]), 0);
      check($sformatf("abort2_done%0d", i), 32'(done[i]), 0);
    end

    // Reset in the middle of the first CHECK of instance 0.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      exp_fv[i]   = 2'b00;
      exp_pass[i] = 1'b0;
    end
    @(posedge clk); #1;
    check_reset_vals("rst_after");
    do_run(0);

    for (int r = 0; r < 5; r++) do_run(int'($urandom_range(0, 4)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
